// File: rtl/csi2_4to1_pkg.sv
// Shared types and constants for the 4-to-1 CSI-2 packet scheduler.
package csi2_4to1_pkg;

  localparam int NUM_CH = 4;
  localparam int IDX_W  = 2;
  localparam int VC_W   = 2;
  localparam int DT_W   = 6;
  localparam int WC_W   = 16;

  // Scheduler FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_XFER,
    ST_GAP
  } sched_state_e;

  // CSI-2 short-packet data types.
  localparam logic [DT_W-1:0] DT_FS = 6'h00;
  localparam logic [DT_W-1:0] DT_FE = 6'h01;
  localparam logic [DT_W-1:0] DT_LS = 6'h02;
  localparam logic [DT_W-1:0] DT_LE = 6'h03;

endpackage

// File: rtl/csi2_rr_arb4.sv
// Combinational 4-way round-robin arbiter: the first requester found when
// scanning upward from the pointer (with wrap) wins.
module csi2_rr_arb4
  import csi2_4to1_pkg::*;
(
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o
);

  logic             found;
  logic [IDX_W-1:0] k;

  // Scan the four positions starting at the pointer; the 2-bit index wraps naturally.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      k = ptr_i + IDX_W'(i);
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/csi2_4to1_pkt_sched.sv
// Packet scheduler for the 4-to-1 CSI-2 merger: picks one channel (shorts
// before longs, round-robin within a class), drives the packetiser until it
// reports completion or the watchdog expires, then inserts an LP gap.
module csi2_4to1_pkt_sched
  import csi2_4to1_pkg::*;
#(
  parameter int GAP_CYC = 4,
  parameter int TO_W    = 16
) (
  input  logic                     core_clk_i,
  input  logic                     core_rstn,
  input  logic [NUM_CH-1:0]        ch_sp_req_i,
  input  logic [NUM_CH-1:0]        ch_lp_req_i,
  input  logic [NUM_CH*DT_W-1:0]   ch_dt_i,
  input  logic [NUM_CH*WC_W-1:0]   ch_wc_i,
  output logic [NUM_CH-1:0]        ch_gnt_o,
  output logic [NUM_CH-1:0]        ch_done_o,
  output logic [IDX_W-1:0]         byte_sel_o,
  output logic [VC_W-1:0]          vc_o,
  output logic [DT_W-1:0]          dt_o,
  output logic [WC_W-1:0]          wc_o,
  output logic                     sp_req_o,
  output logic                     lp_req_o,
  input  logic                     d_hs_rdy_i,
  input  logic                     phdr_xfr_done_i,
  output logic                     busy_o,
  output logic                     to_err_o
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DT_W-1:0]   dt_q, dt_d;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic              sp_q, sp_d;
  logic              lp_q, lp_d;
  logic              to_err_q, to_err_d;
  logic [TO_W-1:0]   wd_q, wd_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic [DT_W-1:0]   dt_arr [NUM_CH];
  logic [WC_W-1:0]   wc_arr [NUM_CH];
  logic [NUM_CH-1:0] sp_gnt, lp_gnt, win_gnt;
  logic [IDX_W-1:0]  sp_idx, lp_idx, win_idx;
  logic              win_sp, req_any;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign dt_arr[g] = ch_dt_i[g*DT_W +: DT_W];
    assign wc_arr[g] = ch_wc_i[g*WC_W +: WC_W];
  end

  csi2_rr_arb4 u_arb_sp (
    .req_i (ch_sp_req_i),
    .ptr_i (rr_q),
    .gnt_o (sp_gnt),
    .idx_o (sp_idx)
  );

  csi2_rr_arb4 u_arb_lp (
    .req_i (ch_lp_req_i),
    .ptr_i (rr_q),
    .gnt_o (lp_gnt),
    .idx_o (lp_idx)
  );

  // Any pending short request takes the whole arbitration away from longs.
  assign win_sp  = |ch_sp_req_i;
  assign win_gnt = win_sp ? sp_gnt : lp_gnt;
  assign win_idx = win_sp ? sp_idx : lp_idx;
  assign req_any = |(ch_sp_req_i | ch_lp_req_i);

  // Next-state and next-output computation for the scheduler FSM.
  always_comb begin
    // NOTE: every target is defaulted up front so no branch can leave one unassigned and infer a latch.
    state_d  = state_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    idx_d    = idx_q;
    dt_d     = dt_q;
    wc_d     = wc_q;
    sp_d     = sp_q;
    lp_d     = lp_q;
    to_err_d = 1'b0;
    wd_d     = wd_q;
    gap_d    = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_any) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (!req_any) begin
          state_d = ST_IDLE;
        end else if (d_hs_rdy_i) begin
          gnt_d   = win_gnt;
          idx_d   = win_idx;
          dt_d    = dt_arr[win_idx];
          wc_d    = wc_arr[win_idx];
          sp_d    = win_sp;
          lp_d    = ~win_sp;
          rr_d    = win_idx + IDX_W'(1);
          wd_d    = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        wd_d = wd_q + TO_W'(1);
        // A real completion wins over a watchdog expiry in the same cycle.
        if (phdr_xfr_done_i || (wd_d == {TO_W{1'b1}})) begin
          to_err_d = ~phdr_xfr_done_i;
          done_d   = gnt_q;
          gnt_d    = '0;
          sp_d     = 1'b0;
          lp_d     = 1'b0;
          gap_d    = '0;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge core_clk_i or negedge core_rstn) begin
    if (!core_rstn) begin
      state_q  <= ST_IDLE;
      rr_q     <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      idx_q    <= '0;
      dt_q     <= '0;
      wc_q     <= '0;
      sp_q     <= 1'b0;
      lp_q     <= 1'b0;
      to_err_q <= 1'b0;
      wd_q     <= '0;
      gap_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      idx_q    <= idx_d;
      dt_q     <= dt_d;
      wc_q     <= wc_d;
      sp_q     <= sp_d;
      lp_q     <= lp_d;
      to_err_q <= to_err_d;
      wd_q     <= wd_d;
      gap_q    <= gap_d;
    end
  end

  assign ch_gnt_o   = gnt_q;
  assign ch_done_o  = done_q;
  assign byte_sel_o = idx_q;
  assign vc_o       = idx_q;
  assign dt_o       = dt_q;
  assign wc_o       = wc_q;
  assign sp_req_o   = sp_q;
  assign lp_req_o   = lp_q;
  assign to_err_o   = to_err_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: doc/csi2_4to1_pkt_sched.md
Name: csi2_4to1_pkt_sched

Overview:
- Packet scheduler for the 4-to-1 CSI-2 merger.
- Four upstream pixel2byte channels request short packets (FS/FE/LS/LE) or long packets (payload lines).
- The block arbitrates between them and drives the single packet-header/D-PHY packetiser: vc/dt/wc, sp_req/lp_req, and the byte-data mux select.
- It holds each grant until the packetiser reports header/payload transfer done, then enforces an inter-packet LP gap.

Parameters:
- NUM_CH, 4, number of requesting channels (fixed at 4; the VC equals the channel index).
- GAP_CYC, 4, idle cycles inserted after each packet completes (min 1).
- TO_W, 16, watchdog counter width; timeout = 2^TO_W - 1 cycles.

Ports:
- core_clk_i  in  1  core byte clock.
- core_rstn  in  1  asynchronous active-low reset.
- ch_sp_req_i  in  4  per-channel short-packet request, level, held until ch_done_o.
- ch_lp_req_i  in  4  per-channel long-packet request, level, held until ch_done_o.
- ch_dt_i  in  24  per-channel data type, 6 bits each; channel k uses bits [6k+5:6k].
- ch_wc_i  in  64  per-channel word count / short-packet data field, 16 bits each.
- ch_gnt_o  out  4  one-hot grant, held for the whole packet.
- ch_done_o  out  4  one-cycle pulse to the granted channel on completion or abort.
- byte_sel_o  out  2  mux select for the packetiser's byte_data/byte_data_en source.
- vc_o  out  2  virtual channel to the packetiser.
- dt_o  out  6  data type to the packetiser.
- wc_o  out  16  word count to the packetiser.
- sp_req_o  out  1  short-packet request to the packetiser, level.
- lp_req_o  out  1  long-packet request to the packetiser, level.
- d_hs_rdy_i  in  1  packetiser/D-PHY ready for a new HS burst.
- phdr_xfr_done_i  in  1  packetiser pulse: packet fully transferred.
- busy_o  out  1  high in any state other than IDLE.
- to_err_o  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset values (async, immediate, mid-packet included): all outputs 0, FSM=IDLE, RR pointer=0, counters=0. No partial handshake survives reset.
- Request vector: req[k] = ch_sp_req_i[k] | ch_lp_req_i[k].
- If a channel asserts both requests, the short packet is served first and the long packet on its next grant.
- Priority: any pending short request beats any long request. Within each class, round-robin starts at RR pointer.
- RR pointer = granted index + 1 (mod 4), updated at grant.
- FSM states:
  - IDLE: if any req, go to ARB.
  - ARB: wait for d_hs_rdy_i=1. On the cycle it is sampled high, register the winner:
    - ch_gnt_o one-hot; byte_sel_o = idx; vc_o = idx; dt_o/wc_o = winner's fields (latched, stable until done).
    - Set sp_req_o or lp_req_o. Go to XFER.
  - XFER: hold all outputs. Watchdog increments each cycle.
    - On phdr_xfr_done_i: drop sp/lp_req_o and ch_gnt_o, pulse ch_done_o[idx], go to GAP.
    - If watchdog reaches all-ones first: same exit actions plus a to_err_o pulse.
  - GAP: count GAP_CYC cycles, then go to IDLE. Requests are ignored during GAP.
- Latency: request seen in IDLE with d_hs_rdy_i=1 gives sp/lp_req_o asserted 2 cycles later (IDLE→ARB, ARB register).
- Minimum packet-to-packet spacing from phdr_xfr_done_i to the next req_o: GAP_CYC + 2 cycles.
- A request deasserted while not granted simply drops out of arbitration.
- A request deasserted while granted is ignored; the packet completes.
- phdr_xfr_done_i outside XFER is ignored.
- Done and timeout in the same cycle: treated as done, no to_err_o.
- wc=0 on a long request: legal, passed through unchanged.
- Watchdog clears on entry to XFER. No wrap: it saturates into abort.
- Exactly one of sp_req_o/lp_req_o is high at a time. ch_gnt_o is one-hot or zero.

Decomposition:
- Shared package csi2_4to1_pkg:
  - NUM_CH and field widths (VC_W=2, DT_W=6, WC_W=16).
  - FSM state encoding (IDLE, ARB, XFER, GAP).
  - CSI-2 short-packet DT constants (FS=6'h00, FE=6'h01, LS=6'h02, LE=6'h03).
- One sub-module: csi2_rr_arb4. It takes a 4-bit request vector and a pointer, and returns a one-hot grant plus a 2-bit index; purely combinational. It is instantiated twice, once for short and once for long requests.

Test Plan:
- Single long request, ch2, dt=6'h2B, wc=16'd1280, d_hs_rdy_i=1:
  - lp_req_o rises 2 cycles later with vc_o=2, byte_sel_o=2, wc_o=1280.
  - Done pulse → ch_done_o=4'b0100 for 1 cycle; next grant is not earlier than GAP_CYC+2 cycles.
- All four channels assert long requests together, each pulses done:
  - Grants go ch0, ch1, ch2, ch3, ch0.
  - RR pointer wraps 3→0.
- ch1 long and ch3 short pending at the same arbitration: ch3 is granted first with sp_req_o=1 and dt_o=6'h00; ch1 follows.
- d_hs_rdy_i held low for 50 cycles with ch0 pending: FSM stays in ARB, no req_o. d_hs_rdy_i rises → grant on that cycle's edge.
- TO_W=4 and phdr_xfr_done_i never pulses: after 15 XFER cycles, to_err_o and ch_done_o pulse together and req_o drops.
- core_rstn asserted mid-XFER: all outputs are 0 asynchronously. After release with requests held, arbitration restarts from ch0.
